uart_rx_param: RTL and testbench

//  Parametrised UART receiver: oversampled start detect, mid-bit sampling, LSB-first

---
 rtl/uart_rx_param.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampled UART receiver with parity/framing flags and valid/ready output
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 r_reset,
  input  logic                 baud_tick,
  input  logic                 serial_i,
  input  logic                 ready_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW = $clog2(OVERSAMPLE);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  localparam logic [CW-1:0] CNT_HALF      = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST      = CW'(OVERSAMPLE - 1);
  localparam logic [3:0]    IDX_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    IDX_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD       = (PARITY == 1);

  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic                 par_acc_q, par_acc_d;
  logic                 frm_acc_q, frm_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 line;
  logic                 bit_end;
  logic                 complete;
  logic                 handshake;

  // next-state: synchroniser, frame FSM with bit counters, and output word/handshake
  always_comb begin
    sync1_d   = serial_i;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    par_acc_d = par_acc_q;
    frm_acc_d = frm_acc_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    complete  = 1'b0;
    line      = sync2_q;
    bit_end   = (cnt_q == CNT_LAST);
    handshake = valid_q & ready_i;

    if (baud_tick) begin
      // a held-low break keeps armed clear, so it cannot look like a new start bit
      if (line) armed_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (!line && armed_q) begin
            state_d   = S_START;
            cnt_d     = '0;
            idx_d     = '0;
            par_acc_d = 1'b0;
            frm_acc_d = 1'b0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d   = '0;
            state_d = line ? S_IDLE : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA, S_PAR, S_STOP: begin
          if (!bit_end) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (state_q == S_DATA) begin
              shift_d = {line, shift_q[DATA_BITS-1:1]};
              if (idx_q == IDX_DATA_LAST) begin
                idx_d   = '0;
                state_d = (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end else if (state_q == S_PAR) begin
              par_acc_d = (((^shift_q) ^ line) != PAR_ODD);
              state_d   = S_STOP;
            end else begin
              if (!line) begin
                frm_acc_d = 1'b1;
                armed_d   = 1'b0;
              end
              if (idx_q == IDX_STOP_LAST) begin
                complete = 1'b1;
                state_d  = S_IDLE;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (complete) begin
      if (!valid_q || ready_i) begin
        data_d  = shift_q;
        perr_d  = par_acc_q;
        ferr_d  = frm_acc_q | ~line;
        valid_d = 1'b1;
        if (handshake) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // state registers; reset discards any frame in flight
  always_ff @(posedge clk) begin
    if (r_reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      par_acc_q <= 1'b0;
      frm_acc_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      par_acc_q <= par_acc_d;
      frm_acc_q <= frm_acc_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed scoreboard bench for uart_rx_param across parameter variants
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       r_reset = 1'b1;
  logic       baud_tick = 1'b1;
  logic       ready = 1'b1;
  logic       ser [5];
  logic [7:0] d8 [4];
  logic [8:0] d9;
  logic       vld [5];
  logic       pe [5];
  logic       fe [5];
  logic       ov [5];
  logic       bz [5];

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   hs_cnt [5] = '{0, 0, 0, 0, 0};
  int   vcyc [5] = '{0, 0, 0, 0, 0};
  logic bz_at_hs [5];
  int   tick_div = 1;

  always #5 clk = ~clk;

  uart_rx_param u0 (.clk(clk), .r_reset(r_reset), .baud_tick(baud_tick), .serial_i(ser[0]),
    .ready_i(ready), .data_o(d8[0]), .valid_o(vld[0]), .parity_err_o(pe[0]),
    .frame_err_o(fe[0]), .overrun_o(ov[0]), .busy_o(bz[0]));
  uart_rx_param #(.PARITY(2)) u1 (.clk(clk), .r_reset(r_reset), .baud_tick(baud_tick),
    .serial_i(ser[1]), .ready_i(ready), .data_o(d8[1]), .valid_o(vld[1]), .parity_err_o(pe[1]),
    .frame_err_o(fe[1]), .overrun_o(ov[1]), .busy_o(bz[1]));
  uart_rx_param #(.PARITY(1)) u2 (.clk(clk), .r_reset(r_reset), .baud_tick(baud_tick),
    .serial_i(ser[2]), .ready_i(ready), .data_o(d8[2]), .valid_o(vld[2]), .parity_err_o(pe[2]),
    .frame_err_o(fe[2]), .overrun_o(ov[2]), .busy_o(bz[2]));
  uart_rx_param #(.STOP_BITS(2)) u3 (.clk(clk), .r_reset(r_reset), .baud_tick(baud_tick),
    .serial_i(ser[3]), .ready_i(ready), .data_o(d8[3]), .valid_o(vld[3]), .parity_err_o(pe[3]),
    .frame_err_o(fe[3]), .overrun_o(ov[3]), .busy_o(bz[3]));
  uart_rx_param #(.DATA_BITS(9)) u4 (.clk(clk), .r_reset(r_reset), .baud_tick(baud_tick),
    .serial_i(ser[4]), .ready_i(ready), .data_o(d9), .valid_o(vld[4]), .parity_err_o(pe[4]),
    .frame_err_o(fe[4]), .overrun_o(ov[4]), .busy_o(bz[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] dout(input int k);
    return (k == 4) ? d9 : {1'b0, d8[k]};
  endfunction

  function automatic logic par_exp(input logic [8:0] d, input int nb, input logic pbit, input bit odd);
    int ones = int'(pbit);
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return odd ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  task automatic push(input int k, input logic [8:0] d, input logic p, input logic f);
    exp_t e;
    e.k = k; e.d = d; e.pe = p; e.fe = f;
    sb.push_back(e);
  endtask

  // scoreboard: every accepted word is popped and compared
  always @(negedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (vld[k] === 1'b1) vcyc[k]++;
      if (vld[k] === 1'b1 && ready === 1'b1) begin
        hs_cnt[k]++;
        bz_at_hs[k] = bz[k];
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_word inst=%0d observed=%0h expected=none", k, dout(k));
        end
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_inst", k, e.k);
          chk("sb_data", dout(k), e.d);
          chk("sb_parity_err", pe[k], e.pe);
          chk("sb_frame_err", fe[k], e.fe);
        end
      end
    end
  end

  // baud tick: every tick_div-th clock
  initial begin
    int c = 0;
    forever begin
      @(posedge clk);
      #1;
      c++;
      baud_tick = (c % tick_div == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input int k, input logic v, input int nb);
    ser[k] = v;
    repeat (nb * 16 * tick_div) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int k, input logic [8:0] d, input int nb, input bit par_en,
                            input logic pbit, input logic s0, input logic s1, input int nstop);
    hold(k, 1'b0, 1);
    for (int i = 0; i < nb; i++) hold(k, d[i], 1);
    if (par_en) hold(k, pbit, 1);
    hold(k, s0, 1);
    if (nstop == 2) hold(k, s1, 1);
  endtask

  initial begin
    int  h;
    bit  saw;
    for (int k = 0; k < 5; k++) ser[k] = 1'b1;
    r_reset = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", vld[0], 0);
    chk("rst_data", d8[0], 0);
    chk("rst_busy", bz[0], 0);
    chk("rst_overrun", ov[0], 0);
    chk("rst_flags", {pe[0], fe[0]}, 0);
    @(posedge clk); #1 r_reset = 1'b0;
    idle(5);

    // basic 8N1 frame
    vcyc[0] = 0;
    h = hs_cnt[0];
    push(0, 9'h0A5, 1'b0, 1'b0);
    send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t1_words", hs_cnt[0], h + 1);
    chk("t1_valid_cycles", vcyc[0], 1);
    chk("t1_busy_at_valid", bz_at_hs[0], 0);
    chk("t1_sb_empty", sb.size(), 0);

    // parity, even then odd
    push(1, 9'h007, par_exp(9'h007, 8, 1'b0, 0), 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    push(1, 9'h007, par_exp(9'h007, 8, 1'b1, 0), 1'b0);
    send_frame(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1, 1);
    idle(16);
    push(2, 9'h007, par_exp(9'h007, 8, 1'b0, 1), 1'b0);
    send_frame(2, 9'h007, 8, 1, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t2_sb_empty", sb.size(), 0);

    // framing error followed by a long break, then recovery
    h = hs_cnt[0];
    push(0, 9'h03C, 1'b0, 1'b1);
    send_frame(0, 9'h03C, 8, 0, 1'b0, 1'b0, 1'b0, 1);
    hold(0, 1'b0, 40);
    chk("t3_break_one_word", hs_cnt[0], h + 1);
    hold(0, 1'b1, 2);
    push(0, 9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t3_recover_words", hs_cnt[0], h + 2);
    push(3, 9'h096, 1'b0, 1'b1);
    send_frame(3, 9'h096, 8, 0, 1'b0, 1'b1, 1'b0, 2);
    hold(3, 1'b1, 2);
    chk("t3_sb_empty", sb.size(), 0);

    // short glitch rejected
    h = hs_cnt[0];
    ser[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 ser[0] = 1'b1;
    saw = 0;
    repeat (20) begin
      @(negedge clk);
      if (bz[0] === 1'b1) saw = 1;
    end
    chk("t4_busy_seen", saw, 1);
    chk("t4_busy_end", bz[0], 0);
    chk("t4_no_word", hs_cnt[0], h);

    // overrun and its clearing
    ready = 1'b0;
    push(0, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h011, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 9'h022, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t5_valid_held", vld[0], 1);
    chk("t5_data_kept", d8[0], 8'h11);
    chk("t5_overrun", ov[0], 1);
    ready = 1'b1;
    @(posedge clk); #1 ready = 1'b0;
    @(negedge clk);
    chk("t5_valid_clr", vld[0], 0);
    chk("t5_overrun_clr", ov[0], 0);
    chk("t5_data_hold", d8[0], 8'h11);
    push(0, 9'h033, 1'b0, 1'b0);
    send_frame(0, 9'h033, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t5_pending", vld[0], 1);
    ready = 1'b1;
    push(0, 9'h044, 1'b0, 1'b0);
    send_frame(0, 9'h044, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t5_no_overrun", ov[0], 0);
    chk("t5_sb_empty", sb.size(), 0);

    // reset mid-frame, then slow baud tick and 9-bit variant
    ready = 1'b0;
    send_frame(0, 9'h077, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    send_frame(0, 9'h078, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(16);
    chk("t6_pre_overrun", ov[0], 1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 1);
    hold(0, 1'b0, 1);
    hold(0, 1'b1, 1);
    ser[0] = 1'b0;
    idle(8);
    chk("t6_busy_mid", bz[0], 1);
    r_reset = 1'b1;
    ser[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_valid", vld[0], 0);
    chk("t6_rst_data", d8[0], 0);
    chk("t6_rst_overrun", ov[0], 0);
    chk("t6_rst_busy", bz[0], 0);
    @(posedge clk); #1 r_reset = 1'b0;
    ready = 1'b1;
    tick_div = 3;
    idle(10);
    push(0, 9'h05A, 1'b0, 1'b0);
    send_frame(0, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(64);
    push(4, 9'h1A5, 1'b0, 1'b0);
    send_frame(4, 9'h1A5, 9, 0, 1'b0, 1'b1, 1'b1, 1);
    idle(64);
    chk("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
